// File: rtl/cmd_pkg.sv
// Shared definitions for the command sequencer: command word layout, opcodes and FSM states.
package cmd_pkg;

   localparam int unsigned CMD_W = 6;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [1:0] OP_HALT  = 2'b11;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

   function automatic logic [7:0] decode_we(input logic [2:0] idx);
      return 8'b0000_0001 << idx;
   endfunction

endpackage

// File: rtl/cmd_mem.sv
// Program memory for cmd_sequencer: register array cleared by reset, one write port and
// one combinational read port.
module cmd_mem
   import cmd_pkg::*;
#(
   parameter int unsigned NUM_CMDS = 16,
   parameter int unsigned PC_W     = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             wr_en,
   input  logic [PC_W-1:0]  wr_addr,
   input  logic [CMD_W-1:0] wr_data,
   input  logic [PC_W-1:0]  rd_addr,
   output logic [CMD_W-1:0] rd_data
);

   logic [CMD_W-1:0] mem_q [NUM_CMDS];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < int'(NUM_CMDS); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/cmd_sequencer.sv
// Programmable command sequencer driving register write enables, store mux select and
// data-memory write enable. Optional store timeout enabled by defining STORE_TIMEOUT_EN.
module cmd_sequencer
   import cmd_pkg::*;
#(
   parameter int unsigned NUM_CMDS = 16,
   parameter int unsigned PC_W     = 4,
   parameter int unsigned TIMEOUT  = 8
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            start,
   input  logic            prog_we,
   input  logic [PC_W-1:0] prog_addr,
   input  logic [5:0]      prog_data,
   input  logic            mem_ready,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic [PC_W-1:0] pc,
   output logic [7:0]      we,
   output logic [1:0]      jklm_select,
   output logic            data_we
);

   state_e           state_q;
   logic [PC_W-1:0]  pc_q;
   logic [CMD_W-1:0] cmd;
   logic [1:0]       op;
   logic [3:0]       arg;
   logic             run;
   logic             last_cmd;
   logic             step;
   logic             unused_arg;

   // Program writes are only accepted while not executing.
   cmd_mem #(
      .NUM_CMDS (NUM_CMDS),
      .PC_W     (PC_W)
   ) u_cmd_mem (
      .Clk     (Clk),
      .Reset   (Reset),
      .wr_en   (prog_we & ~busy),
      .wr_addr (prog_addr),
      .wr_data (prog_data),
      .rd_addr (pc_q),
      .rd_data (cmd)
   );

   assign op         = cmd[5:4];
   assign arg        = cmd[3:0];
   assign unused_arg = arg[3];
   assign run        = (state_q == StRun);
   assign last_cmd   = (pc_q == PC_W'(NUM_CMDS - 1));

   // Command completes this cycle and the program moves on (or implicitly halts).
   assign step = run && ((op == OP_NOP) || (op == OP_LOAD) || ((op == OP_STORE) && mem_ready));

`ifdef STORE_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] stall_q;
   logic             error_q;
   logic             stall_expired;

   assign stall_expired = (stall_q == CNT_W'(TIMEOUT - 1));
   assign error         = error_q;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT == 0);
   assign error          = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         pc_q    <= '0;
`ifdef STORE_TIMEOUT_EN
         stall_q <= '0;
         error_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StRun;
                  pc_q    <= '0;
`ifdef STORE_TIMEOUT_EN
                  stall_q <= '0;
                  error_q <= 1'b0;
`endif
               end
            end
            StRun: begin
               if (step) begin
                  if (last_cmd) begin
                     state_q <= StDone;
                  end else begin
                     pc_q <= pc_q + PC_W'(1);
                  end
`ifdef STORE_TIMEOUT_EN
                  stall_q <= '0;
`endif
               end else if (op == OP_HALT) begin
                  state_q <= StDone;
               end
`ifdef STORE_TIMEOUT_EN
               else if (stall_expired) begin
                  state_q <= StDone;
                  error_q <= 1'b1;
                  stall_q <= '0;
               end else begin
                  stall_q <= stall_q + CNT_W'(1);
               end
`endif
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      busy        = run;
      done        = (state_q == StDone);
      pc          = pc_q;
      we          = '0;
      jklm_select = '0;
      data_we     = 1'b0;
      if (run) begin
         if (op == OP_LOAD) begin
            we = decode_we(arg[2:0]);
         end else if (op == OP_STORE) begin
            data_we     = 1'b1;
            jklm_select = arg[1:0];
         end
      end
   end

endmodule
